// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-position shift sequencer: op and state
// encodings plus default datapath sizing. Optional build macro ARITH_SHR_EN
// (consumed by shift1_stage) turns OP_SHR into an arithmetic right shift.
package shift_seq_pkg;

    localparam int DEF_W     = 64;
    localparam int DEF_AMT_W = 6;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift1_stage.sv
// Combinational single-position shift/rotate step.
// Build macro ARITH_SHR_EN: when defined, OP_SHR replicates the MSB
// (arithmetic); otherwise OP_SHR fills the MSB with zero (logical).
module shift1_stage
    import shift_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] x_i,
    input  op_e          op_i,
    output logic [W-1:0] y_o
);

    // One-position step; bits shifted out of a non-rotate op are discarded.
    always_comb begin
        y_o = x_i;
        case (op_i)
            OP_SHL: y_o = {x_i[W-2:0], 1'b0};
`ifdef ARITH_SHR_EN
            OP_SHR: y_o = {x_i[W-1], x_i[W-1:1]};
`else
            OP_SHR: y_o = {1'b0, x_i[W-1:1]};
`endif
            OP_ROL: y_o = {x_i[W-2:0], x_i[W-1]};
            OP_ROR: y_o = {x_i[0], x_i[W-1:1]};
            default: y_o = x_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-position shift sequencer: accepts one command, applies the one-bit
// step 'amount' times (one per clock), then holds the result until consumed.
// Build macro ARITH_SHR_EN selects arithmetic right shift inside shift1_stage.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [W-1:0]     cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             busy
);

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic [W-1:0]     step_y;

    shift1_stage #(.W(W)) u_step (
        .x_i (work_q),
        .op_i(op_q),
        .y_o (step_y)
    );

    // State, counter, work and result registers; reset aborts any command.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_SHL;
            cnt_q      <= '0;
            work_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state and handshake decode. The result register is loaded only
    // on entry to DONE so it keeps the last result while a new command runs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        rsp_data_d = rsp_data_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    work_d = cmd_data;
                    op_d   = op_e'(cmd_op);
                    cnt_d  = cmd_amt;
                    if (cmd_amt == '0) begin
                        state_d    = ST_DONE;
                        rsp_data_d = cmd_data;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_y;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_DONE;
                    rsp_data_d = step_y;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign rsp_data = rsp_data_q;

endmodule
